// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// The operands are captured when start is accepted. The core then runs
// 32 unsigned iterations on the operand magnitudes: shift-add for multiply,
// restoring for divide. Sign correction and the divide special cases are
// resolved in a single FIX cycle. The done strobe follows one cycle later.
// Every op has the same latency, including the special cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;        // original operand A, needed for REM by zero
  logic [XLEN-1:0] b_q, b_d;        // original operand B, needed for the special cases
  logic [XLEN-1:0] opnd_q, opnd_d;  // mul: |A| addend, div: |B| divisor
  logic [XLEN-1:0] hi_q, hi_d;      // mul: product high half, div: partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // mul: multiplier/product low half, div: dividend/quotient
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            a_signed_s, b_signed_s;
  logic            in_neg_a_s, in_neg_b_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s;
  logic [XLEN:0]   mul_sum_s;
  logic [XLEN:0]   div_shift_s;
  logic [XLEN+1:0] div_diff_s;
  logic            div_unused_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0] quot_fix_s, rem_fix_s;
  logic            div_zero_s, div_ovf_s;
  logic [XLEN-1:0] fix_res_s;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

  // Operand decode, one iteration step, and the sign/special-case fix-up.
  always_comb begin
    // Signedness of each operand for the incoming op.
    if (funct3[2] == 1'b0) begin
      a_signed_s = (funct3 != 3'd3);
      b_signed_s = (funct3[1] == 1'b0);
    end else begin
      a_signed_s = (funct3[0] == 1'b0);
      b_signed_s = (funct3[0] == 1'b0);
    end
    in_neg_a_s = a_signed_s & rs1_val[XLEN-1];
    in_neg_b_s = b_signed_s & rs2_val[XLEN-1];
    mag_a_s    = in_neg_a_s ? (32'd0 - rs1_val) : rs1_val;
    mag_b_s    = in_neg_b_s ? (32'd0 - rs2_val) : rs2_val;

    // Shift-add step: add the multiplicand when the multiplier LSB is set.
    mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Restoring step: bring the next dividend bit into the remainder and
    // trial-subtract the divisor.
    div_shift_s  = {hi_q, lo_q[XLEN-1]};
    div_diff_s   = {1'b0, div_shift_s} - {2'b00, opnd_q};
    div_unused_s = div_diff_s[XLEN];

    // Restore the result signs from the magnitude results.
    prod_s     = {hi_q, lo_q};
    prod_fix_s = (neg_a_q ^ neg_b_q) ? (64'd0 - prod_s) : prod_s;
    quot_fix_s = (neg_a_q ^ neg_b_q) ? (32'd0 - lo_q) : lo_q;
    rem_fix_s  = neg_a_q ? (32'd0 - hi_q) : hi_q;
    div_zero_s = (b_q == 32'd0);
    div_ovf_s  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF) && (op_q[0] == 1'b0);

    case (op_q)
      3'd0:    fix_res_s = prod_fix_s[XLEN-1:0];
      3'd1,
      3'd2,
      3'd3:    fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'd4,
      3'd5: begin
        if (div_zero_s) begin
          fix_res_s = 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
          fix_res_s = 32'h8000_0000;
        end else begin
          fix_res_s = quot_fix_s;
        end
      end
      3'd6,
      3'd7: begin
        if (div_zero_s) begin
          fix_res_s = a_q;
        end else if (div_ovf_s) begin
          fix_res_s = 32'd0;
        end else begin
          fix_res_s = rem_fix_s;
        end
      end
      default: fix_res_s = 32'd0;
    endcase
  end

  // Next-state and next-register logic. Defaults hold every register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = funct3;
          a_d     = rs1_val;
          b_d     = rs2_val;
          rd_d    = rd_in;
          neg_a_d = in_neg_a_s;
          neg_b_d = in_neg_b_s;
          cnt_d   = 5'd0;
          hi_d    = 32'd0;
          if (funct3[2]) begin
            lo_d   = mag_a_s;
            opnd_d = mag_b_s;
          end else begin
            lo_d   = mag_b_s;
            opnd_d = mag_a_s;
          end
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (div_diff_s[XLEN+1] == 1'b0) begin
            hi_d = div_diff_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum_s[XLEN:1];
          lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        result_d = fix_res_s;
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers. Reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// The stimulus process pushes the model's expected result, rd and
// done cycle when a start is accepted. The monitor pops and compares on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
    string       name;
  } exp_t;

  exp_t        scb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        post_done = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  always #5 clk = ~clk;

  // Count rising edges so latency can be measured against the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: RV32M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, ua, ub, q;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sbv; return q[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sbv; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: reset values, done pulses against the scoreboard, busy/done shape, result hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
      have_last = 1'b1;
      last_res  = 32'd0;
      last_rd   = 5'd0;
      post_done = 1'b0;
    end else begin
      if (post_done) begin
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        post_done = 1'b0;
      end
      if (done) begin
        if (scb.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = scb.pop_front();
          chk({e.name, "/result"}, result, e.res);
          chk({e.name, "/rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
          chk({e.name, "/latency"}, cyc, e.due);
          chk({e.name, "/busy_at_done"}, {31'd0, busy}, 32'd1);
          last_res  = e.res;
          last_rd   = e.rd;
          have_last = 1'b1;
          post_done = 1'b1;
        end
      end else begin
        if (have_last) begin
          chk("result_held", result, last_res);
          chk("rd_out_held", {27'd0, rd_out}, {27'd0, last_rd});
        end
        if (scb.size() != 0) chk("busy_in_flight", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string nm, output int acc);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        $display("FAIL issue_wait: busy=%0d after 200 cycles, want 0", busy);
        $fatal(1, "busy stuck");
      end
    end
    funct3  = op;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    acc     = cyc;
    @(posedge clk);
    #1;
    e.res  = ref_model(op, a, b);
    e.rd   = rd;
    e.due  = acc + 34;
    e.name = nm;
    scb.push_back(e);
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Stimulus: directed cases, handshake and reset scenarios, then random ops.
  initial begin
    int acc;
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7x-3", acc);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min", acc);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_max", acc);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, "mulhsu", acc);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_-7/2", acc);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_-7/2", acc);
    issue(3'd5, 32'd100, 32'd7, 5'd7, "divu_100/7", acc);
    issue(3'd7, 32'd100, 32'd7, 5'd8, "remu_100/7", acc);
    issue(3'd5, 32'd5, 32'd0, 5'd9, "divu_by0", acc);
    issue(3'd7, 32'd5, 32'd0, 5'd10, "remu_by0", acc);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf", acc);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf", acc);
    issue(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd13, "div_-7/0", acc);
    issue(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd14, "rem_-7/0", acc);

    // A start while busy and a start during DONE must both be ignored.
    issue(3'd4, 32'd20, 32'd3, 5'd15, "div_20/3", acc);
    repeat (10) @(negedge clk);
    funct3 = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd30; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < acc + 34) @(negedge clk);
    funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd31; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    issue(3'd0, 32'd6, 32'd7, 5'd16, "after_hs", acc);

    // Reset in the middle of a multiply: the op must vanish without a done.
    issue(3'd0, 32'd1234, 32'd5678, 5'd17, "aborted", acc);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    scb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (45) @(negedge clk);
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd18, "after_rst", acc);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom), "rand", acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    guard = 0;
    while (scb.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        $display("FAIL drain: %0d results outstanding, want 0", scb.size());
        $fatal(1, "done missing");
      end
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It takes the two register read values (rs1 and rs2 outputs) plus the destination index, and runs a fixed-latency shift-add multiply or restoring divide. It returns a 32-bit result with a one-cycle write-back strobe that feeds the register file's write port (data_in / rd).

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  input  32  operand A (register file rs1 output).
- rs2_val  input  32  operand B (register file rs2 output).
- rd_in  input  5  destination register index.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result/rd_out valid.
- result  output  32  final value; held until the next accepted start.
- rd_out  output  5  captured rd_in; held like result.

## Operation
- States:
  - IDLE: start=1 captures funct3, rs1_val, rs2_val and rd_in, then goes to CALC. Count is set to 0.
  - CALC: one iteration per cycle, 32 cycles. It goes to FIX when count==31.
  - FIX: applies sign/select/special cases, registers result and rd_out, then goes to DONE.
  - DONE: done=1, then IDLE.
- Operands are captured at start. Input changes afterwards have no effect.
- start while busy is ignored. No queuing.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Core datapath is unsigned on magnitudes. Sign is restored in FIX.
- Multiply:
  - Computes the 64-bit product |A|·|B|, negated if sign(A)^sign(B).
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring, 1 quotient bit per CALC cycle, computed on |A| / |B|.
  - Quotient is negated if sign(A)^sign(B). Remainder takes the sign of A.
- Divide by zero (B==0), overriding in FIX:
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → A (original, unsigned-interpreted bits).
- Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- Special cases do not shorten latency. All ops are fixed-latency.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, rd_out=0, internal accumulators/count=0. It takes effect immediately, including mid-operation. The aborted op produces no done.
- With start accepted at edge E0:
  - busy=1 after E0.
  - CALC occupies edges E1..E32.
  - FIX registers result and rd_out at E33.
  - done=1 and busy=1 after E33.
  - At E34: done=0, busy=0.
- Result latency is 33 cycles from the accepting edge. Throughput is one op per 35 cycles.
- A new start is accepted at the first edge where state is IDLE (E35 earliest).
- start asserted during DONE is ignored.
- result and rd_out change only at FIX or reset. They are stable while done=1 and afterwards.

## Test plan
- Reset then MUL: rs1=7, rs2=0xFFFFFFFD (−3), rd=5, start for 1 cycle → done exactly 33 cycles after the accepting edge; result=0xFFFFFFEB, rd_out=5; busy low one cycle later.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Signed divide:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - Latency still 33 for all.
- Handshake: start DIV 20/3; change rs1/rs2 and pulse start with MUL at cycle 10 → first op completes with 6 and no second done appears. Start again after busy falls → new op accepted.
- Reset mid-op: rst low at cycle 15 of a MUL → busy, done, result and rd_out go to 0 immediately. No done pulse after release. A subsequent op completes normally.
